display_arbiter_2x1: RTL and testbench
======================================

Name: display_arbiter_2x1

Overview:
Sequencing controller that shares one 7-segment display path between two requesters, such as game state and a status/message source. It drives the SEL input of the 2:1 7-bit display multiplexer and returns grants to each source. It enforces a minimum hold time per owner, inserts a one-cycle blank gap on every ownership change, and uses round-robin when both sources request. It sits between the game control unit and the display mux.

Parameters:
HOLD_CYCLES, 4, minimum number of cycles a granted source owns the display before it can lose it (must be >= 1)
CNT_W, 16, width of the hold counter (must satisfy 2^CNT_W > HOLD_CYCLES)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  source 0 (mux D0) requests the display; level, held while wanted
req1  input  1  source 1 (mux D1) requests the display; level, held while wanted
gnt0  output  1  source 0 owns the display
gnt1  output  1  source 1 owns the display
sel  output  1  drives mux SEL; 0 = D0, 1 = D1
blank  output  1  surrounding logic forces segments off while high
switch_pulse  output  1  one-cycle pulse on the cycle ownership is newly granted
db_state  output  2  debug state code

Behaviour:
- Interface (already decided): one clock, named clock; reset is synchronous and active-high, named reset.
- All outputs are registered.
- Reset values: state=IDLE, gnt0=0, gnt1=0, sel=0, blank=1, switch_pulse=0, counter=0, last_served=1 (so source 0 wins the first tie).
- States and db_state codes: IDLE=00, OWN0=01, OWN1=10, GAP=11.
- IDLE and GAP share the same arbitration rule:
  - req0 only: go to OWN0.
  - req1 only: go to OWN1.
  - Both: grant the source not equal to last_served.
  - Neither: go to (or stay in) IDLE.
- GAP lasts exactly one cycle. It always exits on the next edge by the rule above.
- Entering OWNx:
  - counter <= 0, gntx <= 1, sel <= x, blank <= 0, switch_pulse <= 1 for that cycle only, last_served <= x.
- In OWNx:
  - counter increments each cycle and saturates at HOLD_CYCLES-1.
  - hold_done = (counter == HOLD_CYCLES-1).
  - Leave to GAP when hold_done and (reqx == 0 or the other source's req == 1).
  - Otherwise stay. A dropped request before hold_done does not release the display early.
- In GAP and IDLE: gnt0=gnt1=0 and blank=1. sel keeps its last value so the mux does not glitch.
- Latency: a request in IDLE gives a grant 1 cycle later. Ownership change is hold_done edge, then 1 GAP cycle, then the new grant, so the other source sees its grant 2 cycles after hold_done.
- gnt0 and gnt1 are never both 1.
- HOLD_CYCLES=1: hold_done is true on the first owned cycle, giving minimum ownership of 1 cycle.
- Reset asserted in any state takes priority over all transitions and returns every register to its reset value on the next edge.

Optional Feature:
PRIORITY1_EN
- Defined:
  - Source 1 is the fixed high-priority source. In IDLE/GAP, req1 always wins.
  - In OWN0, req1 preempts immediately, ignoring hold_done: OWN0 goes to GAP on the next edge.
  - OWN1 is left only when req1 == 0 and hold_done.
  - last_served is still updated but ignored.
- Undefined: round-robin with hold, exactly as in Behaviour.

Test Plan:
Bench uses HOLD_CYCLES=4.
1. Reset, then reset released with req0=req1=0 for 5 cycles -> state 00, gnt0=gnt1=0, sel=0, blank=1, switch_pulse=0 throughout.
2. req0=1 from cycle 0 -> gnt0=1, sel=0, blank=0, switch_pulse=1 at cycle 1 only. req0 dropped at cycle 2 -> gnt0 stays 1 through cycle 4 (hold), GAP at cycle 5, IDLE at cycle 6.
3. req0=req1=1 held constantly from reset -> alternating OWN0 (4 cycles), GAP (1), OWN1 (4), GAP (1), ... with source 0 first. sel toggles only on grant cycles, and gnt0 and gnt1 are never both 1.
4. In OWN1 with req1 held and req0=0 for 20 cycles -> OWN1 persists and the counter saturates at 3. Then req0 rises -> GAP on the next edge, gnt0=1 one cycle after that.
5. Reset asserted during OWN1 at counter=2 -> next edge: state 00, gnt1=0, sel=0, blank=1. With req0=req1=1 after release -> source 0 granted first.
6. With PRIORITY1_EN defined: in OWN0 at counter=0, req1 rises -> GAP next edge, then gnt1=1. With req0=req1=1 constantly -> OWN1 persists indefinitely and gnt0 is never granted.

Source files
------------

// File: rtl/display_arbiter_2x1.sv
// Two-source display arbiter: min-hold ownership, one-cycle blank gap on handover, round-robin on ties.
// Optional macro PRIORITY1_EN makes source 1 a fixed, preempting high-priority source.
module display_arbiter_2x1 #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       sel,
  output logic       blank,
  output logic       switch_pulse,
  output logic [1:0] db_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10,
    GAP  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] counter_reg;
  logic             last_served_reg;

  logic hold_done;
  logic arb_any;
  logic arb_pick;
  logic leave0;
  logic leave1;

  assign hold_done = (counter_reg == HOLD_MAX);
  assign db_state  = state_reg;

  always_comb begin
    arb_any  = req0 | req1;
    arb_pick = 1'b0;
    leave0   = 1'b0;
    leave1   = 1'b0;
`ifdef PRIORITY1_EN
    arb_pick = req1;
    // source 1 preempts source 0 without waiting for the hold to expire
    leave0   = req1 | (hold_done & ~req0);
    leave1   = hold_done & ~req1;
`else
    arb_pick = (req0 & req1) ? ~last_served_reg : req1;
    leave0   = hold_done & (~req0 | req1);
    leave1   = hold_done & (~req1 | req0);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      counter_reg     <= '0;
      last_served_reg <= 1'b1;
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
      sel             <= 1'b0;
      blank           <= 1'b1;
      switch_pulse    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, GAP: begin
          if (arb_any) begin
            state_reg       <= arb_pick ? OWN1 : OWN0;
            counter_reg     <= '0;
            last_served_reg <= arb_pick;
            gnt0            <= ~arb_pick;
            gnt1            <= arb_pick;
            sel             <= arb_pick;
            blank           <= 1'b0;
            switch_pulse    <= 1'b1;
          end else begin
            // sel is left alone so the mux select does not glitch while blanked
            state_reg    <= IDLE;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            blank        <= 1'b1;
            switch_pulse <= 1'b0;
          end
        end
        OWN0: begin
          switch_pulse <= 1'b0;
          if (leave0) begin
            state_reg <= GAP;
            gnt0      <= 1'b0;
            blank     <= 1'b1;
          end else if (!hold_done) begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        OWN1: begin
          switch_pulse <= 1'b0;
          if (leave1) begin
            state_reg <= GAP;
            gnt1      <= 1'b0;
            blank     <= 1'b1;
          end else if (!hold_done) begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter_2x1.sv
// Scoreboard bench for display_arbiter_2x1: directed phases plus random sticky requests,
// checked cycle by cycle against an ownership/time-based reference model.
module tb_display_arbiter_2x1;

  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0  = 1'b0;
  logic       req1  = 1'b0;
  logic       gnt0, gnt1, sel, blank, switch_pulse;
  logic [1:0] db_state;

  display_arbiter_2x1 #(.HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .sel          (sel),
    .blank        (blank),
    .switch_pulse (switch_pulse),
    .db_state     (db_state)
  );

  always #5 clock = ~clock;

  // expected {db_state, gnt0, gnt1, sel, blank, switch_pulse}
  logic [6:0] exp_q[$];
  logic [6:0] exp_v;
  logic [6:0] got_v;
  int n_checks = 0;
  int n_fail   = 0;
  int cycle_no = 0;

  // model: mode 0=nobody owns, 1=owned, 2=handover gap; owned = cycles owned so far
  int m_mode  = 0;
  int m_owner = 0;
  int m_owned = 0;
  int m_last  = 1;
  int m_sel   = 0;
  int m_pulse = 0;

  task automatic model_update(input logic r, input logic a, input logic b);
    int  w;
    bit  done, mine, other, leave;
    if (r) begin
      m_mode = 0; m_sel = 0; m_last = 1; m_pulse = 0; m_owned = 0;
    end else if (m_mode != 1) begin
      if (a || b) begin
`ifdef PRIORITY1_EN
        w = b ? 1 : 0;
`else
        w = (a && b) ? 1 - m_last : (b ? 1 : 0);
`endif
        m_mode = 1; m_owner = w; m_owned = 1; m_sel = w; m_last = w; m_pulse = 1;
      end else begin
        m_mode = 0; m_pulse = 0;
      end
    end else begin
      done  = (m_owned >= HOLD);
      mine  = (m_owner == 1) ? b : a;
      other = (m_owner == 1) ? a : b;
`ifdef PRIORITY1_EN
      leave = (m_owner == 0) ? (b || (done && !a)) : (done && !b);
`else
      leave = done && (!mine || other);
`endif
      m_pulse = 0;
      if (leave) m_mode = 2;
      else m_owned = m_owned + 1;
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [1:0] db;
    db = (m_mode == 0) ? 2'd0 : (m_mode == 2) ? 2'd3 : 2'(m_owner + 1);
    return {db, (m_mode == 1 && m_owner == 0), (m_mode == 1 && m_owner == 1),
            1'(m_sel), (m_mode != 1), 1'(m_pulse)};
  endfunction

  task automatic step(input logic r, input logic a, input logic b);
    @(negedge clock);
    reset = r;
    req0  = a;
    req1  = b;
    model_update(r, a, b);
    exp_q.push_back(model_out());
  endtask

  // monitor: every cycle the DUT presents a full output set
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        cycle_no++;
        exp_v = exp_q.pop_front();
        got_v = {db_state, gnt0, gnt1, sel, blank, switch_pulse};
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got db/g0/g1/sel/blank/pulse=%b required %b",
                   cycle_no, got_v, exp_v);
        end
        n_checks++;
        if (gnt0 && gnt1) begin
          n_fail++;
          $display("FAIL exclusive_grant cycle %0d: got gnt0=%b gnt1=%b required not both 1",
                   cycle_no, gnt0, gnt1);
        end
      end
    end
  end

  initial begin
    logic r0, r1, rs;
    // reset then quiet idle
    step(1, 0, 0); step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    // short req0 pulse still holds for full ownership
    step(0, 1, 0); step(0, 1, 0);
    repeat (6) step(0, 0, 0);
    // both requesting from reset: alternating round-robin
    step(1, 0, 0);
    repeat (30) step(0, 1, 1);
    // req1 alone long enough to saturate hold, then req0 rises
    repeat (25) step(0, 0, 1);
    repeat (6) step(0, 1, 1);
    // reset in the middle of source 1 ownership
    step(1, 0, 0);
    repeat (3) step(0, 0, 1);
    step(1, 1, 1);
    repeat (8) step(0, 1, 1);
    // random sticky requests with occasional reset
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) r0 = ~r0;
      if ($urandom_range(7) == 0) r1 = ~r1;
      rs = ($urandom_range(149) == 0);
      step(rs, r0, r1);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
